clock_catchup_multi: RTL and testbench

// Multi-channel clock-enable generator with delay/catch-up. Each channel divides the reference

---
 rtl/clock_catchup_multi.sv | 134 +++++++++++++
 tb/tb_clock_catchup_multi.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_catchup_multi.sv
// clock_catchup_multi: multi-channel clock-enable generator with delay/catch-up.
//
// Each channel divides the reference tick (ce_in_i) by a runtime ratio. While a
// channel's delay_i bit is high its ce_o bit is forced low. Every natural tick
// missed during that time is added to a debt counter. Once delay_i drops, the
// debt is repaid by asserting ce_o on off-phase reference ticks.
//
// Optional feature: define CCCU_LOCKSTEP_EN to make all channels share a single
// divider, ratio register, debt counter and overflow flag. In that mode the
// effective delay is the OR of all delay_i bits, the ratio comes from channel 0,
// and every output bit is a replica of that shared channel.
//
// Ports:
//   clk_i            reference clock
//   rst_i            synchronous, active-high reset
//   ce_in_i          reference tick qualifier; no state changes when low
//   delay_i          per-channel stall request; ce_o goes low in the same cycle
//   ratio_i          per-channel divide ratio minus 1, DivWidth bits per channel
//   clear_overflow_i clears all sticky overflow bits (a same-cycle set wins)
//   ce_o             per-channel core clock enable (combinational)
//   catching_up_o    per-channel flag, high while the debt counter is non-zero
//   overflow_o       per-channel sticky flag: debt saturated while delayed
module clock_catchup_multi #(
  parameter int unsigned Channels     = 2,
  parameter int unsigned DivWidth     = 4,
  parameter int unsigned CatchUpWidth = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ce_in_i,
  input  logic [Channels-1:0]          delay_i,
  input  logic [Channels*DivWidth-1:0] ratio_i,
  input  logic                         clear_overflow_i,
  output logic [Channels-1:0]          ce_o,
  output logic [Channels-1:0]          catching_up_o,
  output logic [Channels-1:0]          overflow_o
);

`ifdef CCCU_LOCKSTEP_EN
  localparam int unsigned Units = 1;
`else
  localparam int unsigned Units = Channels;
`endif

  // Per-unit view of the inputs; a unit is one divider/debt engine.
  logic [Units-1:0]          unit_delay;
  logic [Units*DivWidth-1:0] unit_ratio;
  logic [Units-1:0]          unit_ce;
  logic [Units-1:0]          unit_cu;
  logic [Units-1:0]          unit_ov;

`ifdef CCCU_LOCKSTEP_EN
  assign unit_delay = |delay_i;
  assign unit_ratio = ratio_i[DivWidth-1:0];
`else
  assign unit_delay = delay_i;
  assign unit_ratio = ratio_i;
`endif

  for (genvar u = 0; u < Units; u++) begin : g_unit
    logic [DivWidth-1:0]     div_q, div_d;
    logic [DivWidth-1:0]     ratio_q, ratio_d;
    logic [CatchUpWidth-1:0] debt_q, debt_d;
    logic                    ovf_q, ovf_d;
    logic                    natural_tick;
    logic                    debt_nonzero;
    logic                    ovf_set;

    assign natural_tick = (div_q == '0);
    assign debt_nonzero = (debt_q != '0);

    always_comb begin
      div_d   = div_q;
      ratio_d = ratio_q;
      debt_d  = debt_q;
      ovf_d   = ovf_q;
      ovf_set = 1'b0;
      if (ce_in_i) begin
        // The divider keeps running during a stall so natural ticks stay in phase.
        if (div_q == ratio_q) begin
          div_d   = '0;
          // New ratio only takes effect at a period boundary.
          ratio_d = unit_ratio[u*DivWidth +: DivWidth];
        end else begin
          div_d = div_q + DivWidth'(1);
        end

        if (unit_delay[u]) begin
          if (natural_tick) begin
            if (debt_q == '1) begin
              ovf_set = 1'b1;
            end else begin
              debt_d = debt_q + CatchUpWidth'(1);
            end
          end
        end else if (!natural_tick && debt_nonzero) begin
          // Off-phase tick spent repaying one unit of debt.
          debt_d = debt_q - CatchUpWidth'(1);
        end

        ovf_d = ovf_set | (ovf_q & ~clear_overflow_i);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        div_q   <= '0;
        ratio_q <= unit_ratio[u*DivWidth +: DivWidth];
        debt_q  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        div_q   <= div_d;
        ratio_q <= ratio_d;
        debt_q  <= debt_d;
        ovf_q   <= ovf_d;
      end
    end

    assign unit_ce[u] = ce_in_i & ~rst_i & ~unit_delay[u] & (natural_tick | debt_nonzero);
    assign unit_cu[u] = debt_nonzero;
    assign unit_ov[u] = ovf_q;
  end

`ifdef CCCU_LOCKSTEP_EN
  assign ce_o          = {Channels{unit_ce[0]}};
  assign catching_up_o = {Channels{unit_cu[0]}};
  assign overflow_o    = {Channels{unit_ov[0]}};
`else
  assign ce_o          = unit_ce;
  assign catching_up_o = unit_cu;
  assign overflow_o    = unit_ov;
`endif

endmodule

// File: tb/tb_clock_catchup_multi.sv
// Testbench for clock_catchup_multi: directed table, hand-written corner
// sequences and randomized stimulus checked against a behavioural model.
module tb_clock_catchup_multi;
  localparam int unsigned Channels     = 2;
  localparam int unsigned DivWidth     = 4;
  localparam int unsigned CatchUpWidth = 2;
  localparam int          DebtMax      = 3;
`ifdef CCCU_LOCKSTEP_EN
  localparam bit Lock = 1'b1;
`else
  localparam bit Lock = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ce_in;
  logic [1:0] delay;
  logic [7:0] ratio;
  logic       clr;
  logic [1:0] ce, cu, ov;

  clock_catchup_multi #(
    .Channels    (Channels),
    .DivWidth    (DivWidth),
    .CatchUpWidth(CatchUpWidth)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ce_in_i         (ce_in),
    .delay_i         (delay),
    .ratio_i         (ratio),
    .clear_overflow_i(clr),
    .ce_o            (ce),
    .catching_up_o   (cu),
    .overflow_o      (ov)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state per engine: position in the period, period length, debt, overflow.
  int pos[2];
  int per[2];
  int debt[2];
  bit ovf[2];

  // Outputs captured at the last sampling point.
  logic [1:0] ce_s, cu_s, ov_s;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unit_of(input int c);
    return Lock ? 0 : c;
  endfunction

  function automatic bit unit_delay(input int u);
    return Lock ? (|delay) : delay[u];
  endfunction

  function automatic logic [1:0] model_ce();
    logic [1:0] r;
    for (int c = 0; c < 2; c++) begin
      int u;
      u = unit_of(c);
      r[c] = ce_in && !rst && !unit_delay(u) && (pos[u] == 0 || debt[u] != 0);
    end
    return r;
  endfunction

  task automatic model_step();
    int nu;
    nu = Lock ? 1 : 2;
    for (int u = 0; u < nu; u++) begin
      logic [3:0] r;
      r = ratio[u*4 +: 4];
      if (rst) begin
        pos[u] = 0; debt[u] = 0; ovf[u] = 1'b0; per[u] = int'(r) + 1;
      end else if (ce_in) begin
        bit nat, set;
        nat = (pos[u] == 0);
        set = 1'b0;
        if (unit_delay(u)) begin
          if (nat) begin
            if (debt[u] == DebtMax) set = 1'b1;
            else debt[u]++;
          end
        end else if (!nat && debt[u] > 0) begin
          debt[u]--;
        end
        ovf[u] = set | (ovf[u] & !clr);
        pos[u]++;
        if (pos[u] == per[u]) begin
          pos[u] = 0;
          per[u] = int'(r) + 1;
        end
      end
    end
  endtask

  // One clock: compare against the model at the falling edge, then advance.
  task automatic cyc();
    logic [1:0] e;
    @(negedge clk);
    ce_s = ce; cu_s = cu; ov_s = ov;
    e = model_ce();
    for (int c = 0; c < 2; c++) begin
      int u;
      u = unit_of(c);
      chk($sformatf("model ce[%0d]", c), int'(ce[c]), int'(e[c]));
      chk($sformatf("model catching_up[%0d]", c), int'(cu[c]), int'(debt[u] != 0));
      chk($sformatf("model overflow[%0d]", c), int'(ov[c]), int'(ovf[u]));
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    cyc();
    chk("ce during reset", int'(ce_s), 0);
    rst = 1'b0;
  endtask

  typedef struct {
    bit dly;
    bit ce;
    bit cu;
    bit ov;
  } vec_t;

  vec_t vec[24];

  initial begin
    logic [6:0] seq5;
    rst = 1'b1; ce_in = 1'b1; delay = 2'b00; clr = 1'b0; ratio = {4'd3, 4'd3};

    // Tests 1 and 2: natural pattern, then an 8-cycle stall and catch-up (channel 0).
    for (int i = 0; i < 8; i++) vec[i] = '{1'b0, (i % 4) == 0, 1'b0, 1'b0};
    for (int i = 8; i < 16; i++) vec[i] = '{1'b1, 1'b0, i != 8, 1'b0};
    vec[16] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vec[17] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vec[18] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vec[19] = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 20; i < 24; i++) vec[i] = '{1'b0, (i % 4) == 0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 24; i++) begin
      delay[0] = vec[i].dly;
      cyc();
      chk($sformatf("table ce row %0d", i), int'(ce_s[0]), int'(vec[i].ce));
      chk($sformatf("table catching_up row %0d", i), int'(cu_s[0]), int'(vec[i].cu));
      chk($sformatf("table overflow row %0d", i), int'(ov_s[0]), int'(vec[i].ov));
    end
    delay = 2'b00;

    // Test 3: saturation with ratio 0; clear during the stall loses to the set.
    ratio = {4'd3, 4'd0};
    do_reset();
    delay[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clr = (i == 4);
      cyc();
    end
    delay[0] = 1'b0; clr = 1'b0;
    cyc();
    chk("overflow kept over clear", int'(ov_s[0]), 1);
    chk("catching_up at saturation", int'(cu_s[0]), 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    cyc();
    chk("overflow cleared", int'(ov_s[0]), 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("ratio 0 debt never drains", int'(cu_s[0]), 1);
    end

    // Test 4: ce_in toggling with a delay pulse.
    ratio = {4'd3, 4'd1};
    do_reset();
    for (int i = 0; i < 24; i++) begin
      ce_in = (i % 2) == 0;
      delay[0] = (i >= 6 && i < 12);
      cyc();
      if (!ce_in) chk("ce low while ce_in low", int'(ce_s), 0);
    end
    ce_in = 1'b1; delay = 2'b00;

    // Test 5: ratio change mid-period, then reset during catch-up.
    ratio = {4'd3, 4'd3};
    do_reset();
    cyc();
    chk("ratio change first tick", int'(ce_s[0]), 1);
    ratio[3:0] = 4'd1;
    seq5 = 7'b0101000; // bit i = expected ce at step i
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk($sformatf("ratio change step %0d", i), int'(ce_s[0]), int'(seq5[i]));
    end
    delay[0] = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    delay[0] = 1'b0;
    rst = 1'b1;
    cyc();
    chk("debt pending at reset", int'(cu_s[0]), 1);
    chk("ce low in reset", int'(ce_s[0]), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("catching_up cleared by reset", int'(cu_s[0]), 0);
      chk($sformatf("post-reset pattern %0d", i), int'(ce_s[0]), int'((i % 2) == 0));
    end

    // Test 6: delay on channel 0 only.
    ratio = {4'd3, 4'd3};
    do_reset();
    delay = 2'b01;
    for (int i = 0; i < 6; i++) begin
      cyc();
`ifdef CCCU_LOCKSTEP_EN
      chk("lockstep ce replicated", int'(ce_s[1]), int'(ce_s[0]));
`else
      chk("channel 1 unaffected", int'(ce_s[1]), int'((i % 4) == 0));
`endif
    end
    delay = 2'b00;
    cyc();
`ifdef CCCU_LOCKSTEP_EN
    chk("lockstep catching_up", int'(cu_s), 3);
`else
    chk("independent catching_up", int'(cu_s), 1);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      ce_in = ($urandom_range(0, 3) != 0);
      delay = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) begin
        ratio[3:0] = 4'($urandom_range(0, 15));
        ratio[7:4] = 4'($urandom_range(0, 3));
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
